tcdm_preload_engine: RTL

Hardware TCDM fill-and-check engine that drives the external TCDM master port of `hci_system` (`ext_tcdm_*`, HCI protocol). It writes a programmable word pattern over a contiguous address range and can optionally read the range back and count mismatches. It replaces bench-driven TCDM initialization, and also serves as a self-test master in FPGA and emulation builds.

---
 rtl/tcdm_preload_engine.sv | 123 ++++++++++++
 1 files changed

// File: rtl/tcdm_preload_engine.sv
// tcdm_preload_engine: TCDM master that fills an address range with a word pattern and optionally reads it back counting mismatches
module tcdm_preload_engine #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int CNT_WIDTH       = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [1:0]              mode_i,
  input  logic                    verify_i,
  input  logic [ADDR_WIDTH-1:0]   base_addr_i,
  input  logic [CNT_WIDTH-1:0]    n_words_i,
  input  logic [DATA_WIDTH-1:0]   seed_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [CNT_WIDTH-1:0]    err_cnt_o,
  output logic                    tcdm_req_o,
  input  logic                    tcdm_gnt_i,
  output logic [ADDR_WIDTH-1:0]   tcdm_add_o,
  output logic                    tcdm_wen_o,
  output logic [DATA_WIDTH-1:0]   tcdm_data_o,
  output logic [DATA_WIDTH/8-1:0] tcdm_be_o,
  input  logic [DATA_WIDTH-1:0]   tcdm_r_data_i,
  input  logic                    tcdm_r_valid_i,
  output logic                    tcdm_r_ready_o
);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [DATA_WIDTH-1:0] POLY = DATA_WIDTH'(32'h8020_0003);
  typedef enum logic [2:0] {IDLE, WRITE, WDRAIN, READ, RDRAIN, DONE} state_t;
  state_t r_state, w_next;
  logic [1:0]            r_mode;
  logic                  r_verify;
  logic [ADDR_WIDTH-1:0] r_base, r_addr;
  logic [CNT_WIDTH-1:0]  r_n, r_left, r_err;
  logic [DATA_WIDTH-1:0] r_seed, r_data, r_exp, w_seed;
  logic [OW-1:0]         r_out;
  logic                  w_gnt, w_rsp, w_last, w_drained, w_rd_start, w_check;

  function automatic logic [DATA_WIDTH-1:0] gen_next(input logic [1:0] m, input logic [DATA_WIDTH-1:0] d);
    return m == 2'b00 ? d + DATA_WIDTH'(1) : m == 2'b01 ? (d >> 1) ^ (d[0] ? POLY : '0) : d;
  endfunction

  assign w_seed     = (mode_i == 2'b01 && seed_i == '0) ? DATA_WIDTH'(1) : seed_i;
  assign w_gnt      = tcdm_req_o & tcdm_gnt_i;
  assign w_rsp      = tcdm_r_valid_i & tcdm_r_ready_o;
  assign w_last     = w_gnt && r_left == CNT_WIDTH'(1);
  assign w_drained  = r_out == '0;
  assign w_rd_start = r_state == WDRAIN && w_drained && r_verify;
  assign w_check    = w_rsp && (r_state == READ || r_state == RDRAIN);

  always_ff @(posedge clk_i)
    if (rst_i) r_state <= IDLE;
    else r_state <= w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start_i) w_next = n_words_i == '0 ? DONE : WRITE;
      WRITE:   if (w_last) w_next = WDRAIN;
      WDRAIN:  if (w_drained) w_next = r_verify ? READ : DONE;
      READ:    if (w_last) w_next = RDRAIN;
      RDRAIN:  if (w_drained) w_next = DONE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy_o         = r_state != IDLE;
    done_o         = r_state == DONE;
    err_cnt_o      = r_err;
    tcdm_req_o     = (r_state == WRITE || r_state == READ) && r_out != OW'(MAX_OUTSTANDING);
    tcdm_wen_o     = r_state == READ;
    tcdm_add_o     = r_addr;
    tcdm_data_o    = r_data;
    tcdm_be_o      = {(DATA_WIDTH/8){tcdm_req_o}};
    tcdm_r_ready_o = r_state != IDLE && r_state != DONE;
  end

  always_ff @(posedge clk_i)
    if (rst_i) r_out <= '0;
    else r_out <= r_out + OW'(w_gnt) - OW'(w_rsp);

  always_ff @(posedge clk_i)
    if (rst_i) begin
      r_mode   <= '0;
      r_verify <= 1'b0;
      r_base   <= '0;
      r_addr   <= '0;
      r_n      <= '0;
      r_left   <= '0;
      r_err    <= '0;
      r_seed   <= '0;
      r_data   <= '0;
      r_exp    <= '0;
    end else begin
      if (r_state == IDLE && start_i) begin
        r_mode   <= mode_i;
        r_verify <= verify_i;
        r_base   <= base_addr_i & ~ADDR_WIDTH'(3);
        r_addr   <= base_addr_i & ~ADDR_WIDTH'(3);
        r_n      <= n_words_i;
        r_left   <= n_words_i;
        r_seed   <= w_seed;
        r_data   <= w_seed;
        r_err    <= '0;
      end else if (w_rd_start) begin
        r_addr <= r_base;
        r_left <= r_n;
        r_data <= r_seed;
        r_exp  <= r_seed;
      end else if (w_gnt) begin
        r_addr <= r_addr + ADDR_WIDTH'(4);
        r_left <= r_left - CNT_WIDTH'(1);
        r_data <= gen_next(r_mode, r_data);
      end
      if (w_check) begin
        r_exp <= gen_next(r_mode, r_exp);
        if (tcdm_r_data_i != r_exp && r_err != '1) r_err <= r_err + CNT_WIDTH'(1);
      end
    end
endmodule
